// File: rtl/tm1638_responder.sv
// TM1638 target model: decodes STB/CLK/DIO frames into display RAM and control
// state, and shifts out a 32-bit key word on key-read commands.
module tm1638_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tm_clk,
  input  logic        tm_stb,
  input  logic        tm_dio_in,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic [31:0] keys,
  input  logic [3:0]  ram_rd_addr,
  output logic [7:0]  ram_rd_data,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        frame_done,
  output logic        cmd_err
);

  localparam int unsigned RAM_DEPTH = 16;
  localparam int unsigned KEY_W     = 32;
  localparam int unsigned RCNT_W    = 6;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_IGNORE = 3'd4;

  logic [SYNC_STAGES-1:0] clk_sync, stb_sync, dio_sync;
  logic                   clk_prev, stb_prev;
  logic                   clk_rise_c, clk_fall_c, stb_rise_c, stb_fall_c, dio_bit_c;

  logic [2:0]        state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh_byte;
  logic              byte_valid;
  logic              byte_seen;
  logic [3:0]        addr;
  logic              fixed_mode;
  logic [KEY_W-1:0]  shreg;
  logic [RCNT_W-1:0] rd_cnt;
  logic [7:0]        ram [RAM_DEPTH];
  logic              counting_c;

  // Strobe chain resets low so a strobe already held low across reset
  // release never looks like a new frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      stb_sync <= '0;
      dio_sync <= '1;
      clk_prev <= 1'b1;
      stb_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], tm_clk};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], tm_stb};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], tm_dio_in};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      stb_prev <= stb_sync[SYNC_STAGES-1];
    end
  end

  assign clk_rise_c = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign clk_fall_c = ~clk_sync[SYNC_STAGES-1] & clk_prev;
  assign stb_rise_c = stb_sync[SYNC_STAGES-1] & ~stb_prev;
  assign stb_fall_c = ~stb_sync[SYNC_STAGES-1] & stb_prev;
  assign dio_bit_c  = dio_sync[SYNC_STAGES-1];
  assign counting_c = (state == S_CMD) || (state == S_WDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Strobe rise beats everything; the first byte of a frame steers the FSM.
  always_comb begin
    state_nxt = state;
    if (stb_rise_c) begin
      state_nxt = S_IDLE;
    end else if (stb_fall_c) begin
      state_nxt = S_CMD;
    end else if (byte_valid && (state == S_CMD)) begin
      case (sh_byte[7:6])
        2'b01:   if (sh_byte[1]) state_nxt = S_RDATA;
        2'b11:   state_nxt = S_WDATA;
        2'b00:   state_nxt = S_IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      sh_byte     <= '0;
      byte_valid  <= 1'b0;
      byte_seen   <= 1'b0;
      addr        <= '0;
      fixed_mode  <= 1'b0;
      shreg       <= '0;
      rd_cnt      <= '0;
      disp_on     <= 1'b0;
      brightness  <= '0;
      tm_dio_oe   <= 1'b0;
      tm_dio_out  <= 1'b1;
      frame_done  <= 1'b0;
      cmd_err     <= 1'b0;
      ram_rd_data <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
    end else begin
      frame_done  <= 1'b0;
      cmd_err     <= 1'b0;
      byte_valid  <= 1'b0;
      ram_rd_data <= ram[ram_rd_addr];
      if (stb_rise_c) begin
        bit_cnt    <= '0;
        byte_seen  <= 1'b0;
        tm_dio_oe  <= 1'b0;
        tm_dio_out <= 1'b1;
        cmd_err    <= (bit_cnt != 3'd0);
        frame_done <= byte_seen;
      end else if (stb_fall_c) begin
        bit_cnt    <= '0;
        byte_seen  <= 1'b0;
        tm_dio_oe  <= 1'b0;
        tm_dio_out <= 1'b1;
      end else begin
        if (clk_rise_c && counting_c) begin
          sh_byte <= {dio_bit_c, sh_byte[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            byte_seen  <= 1'b1;
          end
        end
        if (byte_valid && (state == S_CMD)) begin
          case (sh_byte[7:6])
            2'b01: begin
              fixed_mode <= sh_byte[2];
              if (sh_byte[1]) begin
                shreg  <= keys;
                rd_cnt <= '0;
              end
            end
            2'b10: begin
              disp_on    <= sh_byte[3];
              brightness <= sh_byte[2:0];
            end
            2'b11:   addr    <= sh_byte[3:0];
            default: cmd_err <= 1'b1;
          endcase
        end
        if (byte_valid && (state == S_WDATA)) begin
          ram[addr] <= sh_byte;
          if (!fixed_mode) addr <= addr + 4'd1;
        end
        // Key word goes out LSB first; the fall after bit 31 releases DIO.
        if (clk_fall_c && (state == S_RDATA)) begin
          if (rd_cnt < RCNT_W'(KEY_W)) begin
            tm_dio_oe  <= 1'b1;
            tm_dio_out <= shreg[0];
            shreg      <= {1'b0, shreg[KEY_W-1:1]};
            rd_cnt     <= rd_cnt + RCNT_W'(1);
          end else begin
            tm_dio_oe  <= 1'b0;
            tm_dio_out <= 1'b1;
          end
        end
      end
    end
  end

endmodule
